// File: rtl/bus_fabric_if.sv
// Master-side data-port bundle between the MCU core and the bus fabric.
// The master drives requests and the fabric returns registered read responses.
// The slave modport is the fabric's view of the same wires.
interface bus_fabric_if;
  logic        r_en;
  logic [31:0] r_addr;
  logic [31:0] r_data;
  logic        r_valid;
  logic        r_err;
  logic        busy;
  logic        w_en;
  logic [31:0] w_addr;

  modport master (
    output r_en, r_addr, w_en, w_addr,
    input  r_data, r_valid, r_err, busy
  );

  modport slave (
    input  r_en, r_addr, w_en, w_addr,
    output r_data, r_valid, r_err, busy
  );
endinterface

// File: rtl/bus_fabric.sv
// Address decoder and read-response path from the MCU data port onto NSLOT slave windows.
// Latency: writes and slave read enables are combinational; r_valid arrives L+1 cycles after r_en (1 for unmapped).
// Backpressure: one read outstanding; r_en while busy is dropped and flagged in the sticky error.
module bus_fabric #(
  parameter int                  NSLOT     = 4,
  parameter logic [NSLOT*32-1:0] SLOT_BASE = {32'h50, 32'h20, 32'h10, 32'h1000},
  parameter logic [NSLOT*5-1:0]  SLOT_BITS = {5'd4, 5'd4, 5'd4, 5'd12},
  parameter logic [NSLOT*2-1:0]  SLOT_RLAT = {2'd0, 2'd0, 2'd0, 2'd1}
) (
  input  logic                  clk,
  input  logic                  rst,
  bus_fabric_if.slave           bus,
  output logic [NSLOT-1:0]      s_r_en,
  output logic [NSLOT*32-1:0]   s_r_addr,
  input  logic [NSLOT*32-1:0]   s_r_data,
  output logic [NSLOT-1:0]      s_w_en,
  output logic [NSLOT*32-1:0]   s_w_addr,
  output logic                  err,
  output logic [31:0]           err_addr,
  input  logic                  err_clr
);

  localparam int IW = (NSLOT > 1) ? $clog2(NSLOT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERESP} state_t;

  state_t          state, state_nxt;
  logic [1:0]      cnt, cnt_nxt;
  logic [IW-1:0]   slot, slot_nxt, cap_idx;
  logic            capture, eresp, rd_fwd, rd_err, wr_err;
  logic            r_hit, w_hit;
  logic [IW-1:0]   r_idx, w_idx;
  logic [1:0]      r_lat;
  logic [31:0]     s_rd [NSLOT];
  logic [31:0]     r_data_q;
  logic            r_valid_q, r_err_q;

  // Window match: upper address bits above the window exponent equal the base.
  function automatic logic slot_hit(input logic [31:0] a, input int k);
    logic [31:0] mask;
    mask = 32'hFFFF_FFFF << SLOT_BITS[5*k +: 5];
    return (a & mask) == (SLOT_BASE[32*k +: 32] & mask);
  endfunction

  // Relative addresses are driven for every slot; only enables are qualified.
  for (genvar g = 0; g < NSLOT; g++) begin : g_slot
    assign s_r_addr[32*g +: 32] = bus.r_addr - SLOT_BASE[32*g +: 32];
    assign s_w_addr[32*g +: 32] = bus.w_addr - SLOT_BASE[32*g +: 32];
    assign s_rd[g]              = s_r_data[32*g +: 32];
  end

  // Priority decode: scanning downward lets the lowest matching slot win.
  always_comb begin
    r_hit = 1'b0;
    r_idx = '0;
    r_lat = '0;
    w_hit = 1'b0;
    w_idx = '0;
    for (int k = NSLOT - 1; k >= 0; k--) begin
      if (slot_hit(bus.r_addr, k)) begin
        r_hit = 1'b1;
        r_idx = IW'(k);
        r_lat = SLOT_RLAT[2*k +: 2];
      end
      if (slot_hit(bus.w_addr, k)) begin
        w_hit = 1'b1;
        w_idx = IW'(k);
      end
    end
  end

  // Read FSM next state. The cycle of r_en already counts as the first wait
  // cycle, so the counter is loaded with L-1 and an L=0 slave is captured
  // straight from IDLE; this keeps r_valid at t+L+1 with the FSM back in IDLE.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    slot_nxt  = slot;
    cap_idx   = slot;
    capture   = 1'b0;
    eresp     = 1'b0;
    rd_fwd    = 1'b0;
    rd_err    = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.r_en) begin
          if (r_hit) begin
            rd_fwd   = 1'b1;
            slot_nxt = r_idx;
            if (r_lat == 2'd0) begin
              capture = 1'b1;
              cap_idx = r_idx;
            end else begin
              cnt_nxt   = r_lat - 2'd1;
              state_nxt = S_WAIT;
            end
          end else begin
            eresp     = 1'b1;
            rd_err    = 1'b1;
            state_nxt = S_ERESP;
          end
        end
      end
      S_WAIT: begin
        rd_err = bus.r_en;
        if (cnt == 2'd0) begin
          capture   = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          cnt_nxt = cnt - 2'd1;
        end
      end
      S_ERESP: begin
        rd_err    = bus.r_en;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      slot  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      slot  <= slot_nxt;
    end
  end

  // Registered response: one-cycle r_valid pulse, r_data held between responses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data_q  <= '0;
      r_valid_q <= 1'b0;
      r_err_q   <= 1'b0;
    end else begin
      r_valid_q <= capture | eresp;
      r_err_q   <= eresp;
      if (capture)
        r_data_q <= s_rd[cap_idx];
      else if (eresp)
        r_data_q <= '0;
    end
  end

  assign wr_err = bus.w_en & ~w_hit;

  // Sticky error: first address wins, read beats write, new error beats clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      err      <= 1'b0;
      err_addr <= '0;
    end else if (rd_err || wr_err) begin
      if (!err || err_clr) begin
        err      <= 1'b1;
        err_addr <= rd_err ? bus.r_addr : bus.w_addr;
      end
    end else if (err_clr) begin
      err      <= 1'b0;
      err_addr <= '0;
    end
  end

  // One-hot slave enables, forced low during reset.
  always_comb begin
    s_r_en = '0;
    s_w_en = '0;
    if (!rst) begin
      if (rd_fwd)
        s_r_en[r_idx] = 1'b1;
      if (bus.w_en && w_hit)
        s_w_en[w_idx] = 1'b1;
    end
  end

  assign bus.r_data  = r_data_q;
  assign bus.r_valid = r_valid_q;
  assign bus.r_err   = r_err_q;
  assign bus.busy    = (state != S_IDLE);

endmodule

// File: tb/tb_bus_fabric.sv
// Self-checking bench for bus_fabric: table of single reads plus hand sequences.
// Read responses are matched against a scoreboard queue filled at issue time.
// Inputs change on the falling edge; outputs are sampled just after it.
module tb_bus_fabric;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   s_r_en, s_w_en;
  logic [127:0] s_r_addr, s_w_addr, s_r_data;
  logic         err, err_clr;
  logic [31:0]  err_addr;

  bus_fabric_if bus ();

  bus_fabric dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .s_r_en   (s_r_en),
    .s_r_addr (s_r_addr),
    .s_r_data (s_r_data),
    .s_w_en   (s_w_en),
    .s_w_addr (s_w_addr),
    .err      (err),
    .err_addr (err_addr),
    .err_clr  (err_clr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          due;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  en;
    int          slot;
    logic [31:0] rel;
    int          lat;
    logic [31:0] data;
    logic        err;
  } rd_vec_t;
  rd_vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Response monitor: every r_valid must match the oldest expected response.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.r_valid === 1'b1) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_r_valid: got r_valid=1 r_data=%h, expected no response (cycle %0d)",
                   bus.r_data, cyc);
        end else begin
          e = sb.pop_front();
          check("r_data", bus.r_data, e.data);
          check("r_err", {31'b0, bus.r_err}, {31'b0, e.err});
          check("r_valid_cycle", cyc, e.due);
        end
      end
    end
  end

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 10) begin
      @(negedge clk);
      #2;
      n++;
    end
    if (sb.size() != 0) begin
      n_checks++;
      n_err++;
      $display("FAIL drain_timeout: got %0d pending responses, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no end of test, expected $finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{32'h1008, 4'b0001,  0, 32'h008, 1, 32'hDEADBEEF, 1'b0};
    vecs[1] = '{32'h0014, 4'b0010,  1, 32'h004, 0, 32'h000000A5, 1'b0};
    vecs[2] = '{32'h0024, 4'b0100,  2, 32'h004, 0, 32'h12345678, 1'b0};
    vecs[3] = '{32'h005C, 4'b1000,  3, 32'h00C, 0, 32'hCAFEF00D, 1'b0};
    vecs[4] = '{32'h1FFC, 4'b0001,  0, 32'hFFC, 1, 32'hDEADBEEF, 1'b0};
    vecs[5] = '{32'h3000, 4'b0000, -1, 32'h0,   0, 32'h0,        1'b1};
    vecs[6] = '{32'h0030, 4'b0000, -1, 32'h0,   0, 32'h0,        1'b1};
    vecs[7] = '{32'h0FFF, 4'b0000, -1, 32'h0,   0, 32'h0,        1'b1};

    s_r_data   = {32'hCAFEF00D, 32'h12345678, 32'h000000A5, 32'hDEADBEEF};
    rst        = 1'b1;
    bus.r_en   = 1'b1;
    bus.r_addr = 32'h1008;
    bus.w_en   = 1'b1;
    bus.w_addr = 32'h54;
    err_clr    = 1'b0;

    // Reset with both strobes held high.
    repeat (3) begin
      @(negedge clk);
      #1;
      check("rst_s_r_en", {28'b0, s_r_en}, 32'h0);
      check("rst_s_w_en", {28'b0, s_w_en}, 32'h0);
      check("rst_r_valid", {31'b0, bus.r_valid}, 32'h0);
      check("rst_busy", {31'b0, bus.busy}, 32'h0);
      check("rst_err", {31'b0, err}, 32'h0);
    end
    check("rst_r_data", bus.r_data, 32'h0);
    check("rst_r_err", {31'b0, bus.r_err}, 32'h0);
    check("rst_err_addr", err_addr, 32'h0);
    @(negedge clk);
    rst      = 1'b0;
    bus.r_en = 1'b0;
    bus.w_en = 1'b0;

    // Table of single reads.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.r_en   = 1'b1;
      bus.r_addr = vecs[i].addr;
      sb.push_back('{vecs[i].data, vecs[i].err, cyc + vecs[i].lat + 1});
      #1;
      check($sformatf("vec%0d_s_r_en", i), {28'b0, s_r_en}, {28'b0, vecs[i].en});
      if (vecs[i].slot >= 0)
        check($sformatf("vec%0d_s_r_addr", i), s_r_addr[32*vecs[i].slot +: 32], vecs[i].rel);
      @(negedge clk);
      bus.r_en = 1'b0;
      #2;
      drain();
      @(negedge clk);
      #2;
      check($sformatf("vec%0d_r_data_hold", i), bus.r_data, vecs[i].data);
      check($sformatf("vec%0d_busy_idle", i), {31'b0, bus.busy}, 32'h0);
    end

    // Unmapped read then unmapped write: first error address is kept.
    pulse_clr();
    #1;
    check("clr_err", {31'b0, err}, 32'h0);
    @(negedge clk);
    bus.r_en   = 1'b1;
    bus.r_addr = 32'h3000;
    sb.push_back('{32'h0, 1'b1, cyc + 1});
    #1;
    check("unmapped_s_r_en", {28'b0, s_r_en}, 32'h0);
    @(negedge clk);
    bus.r_en   = 1'b0;
    bus.w_en   = 1'b1;
    bus.w_addr = 32'h4000;
    #1;
    check("unmapped_err", {31'b0, err}, 32'h1);
    check("unmapped_err_addr", err_addr, 32'h3000);
    check("unmapped_s_w_en", {28'b0, s_w_en}, 32'h0);
    @(negedge clk);
    bus.w_en = 1'b0;
    #1;
    check("second_err_keeps_addr", err_addr, 32'h3000);
    drain();

    // Read while busy is dropped and flagged.
    pulse_clr();
    @(negedge clk);
    bus.r_en   = 1'b1;
    bus.r_addr = 32'h1000;
    sb.push_back('{32'hDEADBEEF, 1'b0, cyc + 2});
    #1;
    check("b2b_first_s_r_en", {28'b0, s_r_en}, 32'h1);
    @(negedge clk);
    #1;
    check("b2b_second_s_r_en", {28'b0, s_r_en}, 32'h0);
    check("b2b_busy", {31'b0, bus.busy}, 32'h1);
    @(negedge clk);
    bus.r_en = 1'b0;
    #1;
    check("b2b_err", {31'b0, err}, 32'h1);
    check("b2b_err_addr", err_addr, 32'h1000);
    drain();

    // New error in the same cycle as clear wins; clear alone empties.
    @(negedge clk);
    err_clr    = 1'b1;
    bus.w_en   = 1'b1;
    bus.w_addr = 32'h9000;
    @(negedge clk);
    err_clr  = 1'b0;
    bus.w_en = 1'b0;
    #1;
    check("clr_vs_new_err", {31'b0, err}, 32'h1);
    check("clr_vs_new_err_addr", err_addr, 32'h9000);
    pulse_clr();
    #1;
    check("clr_only_err", {31'b0, err}, 32'h0);
    check("clr_only_err_addr", err_addr, 32'h0);

    // Write decode, and simultaneous read and write to one slot.
    @(negedge clk);
    bus.w_en   = 1'b1;
    bus.w_addr = 32'h54;
    #1;
    check("wr54_s_w_en", {28'b0, s_w_en}, 32'h8);
    check("wr54_s_w_addr", s_w_addr[96 +: 32], 32'h4);
    @(negedge clk);
    bus.w_addr = 32'h1010;
    #1;
    check("wr1010_s_w_en", {28'b0, s_w_en}, 32'h1);
    check("wr1010_s_w_addr", s_w_addr[0 +: 32], 32'h10);
    @(negedge clk);
    bus.w_addr = 32'h18;
    bus.r_en   = 1'b1;
    bus.r_addr = 32'h14;
    sb.push_back('{32'h000000A5, 1'b0, cyc + 1});
    #1;
    check("rw_same_s_w_en", {28'b0, s_w_en}, 32'h2);
    check("rw_same_s_r_en", {28'b0, s_r_en}, 32'h2);
    @(negedge clk);
    bus.w_en = 1'b0;
    bus.r_en = 1'b0;
    #2;
    drain();
    check("no_err_after_writes", {31'b0, err}, 32'h0);

    // Reset in the middle of a slot-0 read drops the response.
    @(negedge clk);
    bus.r_en   = 1'b1;
    bus.r_addr = 32'h1004;
    @(negedge clk);
    bus.r_en = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_busy", {31'b0, bus.busy}, 32'h0);
    repeat (3) begin
      @(negedge clk);
      #1;
      check("midrst_no_r_valid", {31'b0, bus.r_valid}, 32'h0);
    end

    check("scoreboard_empty", sb.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
